data_mem_stall: RTL and testbench
=================================

// Module: data_mem_stall
// PURPOSE
//   Multi-cycle data-memory responder on the processor's load/store port.
//   Replaces the single-cycle data memory. Accepts one read or write request
//   at a time, holds Stall high while the access is in flight, then pulses
//   Done with read data. The processor freezes PC and pipeline state while
//   Stall is high.
// PARAMETERS
//   LATENCY  4  cycles from request acceptance to Done; legal range 1..15
//   AW       9  word-index bits; DEPTH = 2**AW 16-bit words
// PORTS
//   clk      in   1   system clock; all state changes on the rising edge
//   rst      in   1   asynchronous active-high reset
//   Addr     in   16  byte address; word index = Addr[AW:1]
//   DataIn   in   16  store data
//   Rd       in   1   load request, level; sampled only in IDLE
//   Wr       in   1   store request, level; sampled only in IDLE
//   DataOut  out  16  load data, registered; valid in the Done cycle, held until the next load completes
//   Done     out  1   one-cycle pulse when the access completes
//   Stall    out  1   access in flight; processor must not advance
//   err      out  1   one-cycle illegal-request flag
// BEHAVIOUR
//   Reset values: DataOut=0, Done=0, Stall=0, err=0, state=IDLE, counter=0.
//   Array contents are not reset.
//   FSM states: IDLE, BUSY, DONE.
//   IDLE, exactly one of Rd/Wr high in cycle T:
//     - latch Addr, DataIn and op; counter=LATENCY-1.
//     - next state is BUSY, or DONE if LATENCY==1.
//   BUSY: counter decrements each cycle; when counter==1, next state is DONE.
//   DONE: Done=1 for exactly one cycle (cycle T+LATENCY); next state is IDLE.
//   Stall is combinational:
//     Stall = (IDLE & (Rd^Wr) & legal) | BUSY.
//     So Stall is high in cycles T..T+LATENCY-1 and low in the Done cycle.
//   Store: array word written at the edge entering DONE, using latched addr/data.
//   Load: array read with the latched address; DataOut registered at the edge
//     entering DONE.
//   Latched inputs are used for the whole access. Changes on Addr, DataIn,
//     Rd or Wr during BUSY or DONE are ignored.
//   No acceptance in the DONE cycle. The processor still presents the same
//     instruction during Done, so a new request is taken only in IDLE (T+LATENCY+1).
//   Rd & Wr both high in IDLE: request rejected, err=1 for that cycle,
//     Stall=0, state stays IDLE.
//   Addr[15:AW+1] ignored: addresses alias modulo DEPTH words (wrap-around).
//   rst mid-access: immediate return to IDLE with Stall/Done/err low. A pending
//     store is discarded; the array is not modified.
//   err is combinational from current inputs and state; it never blocks a later legal request.
// CONFIGURATION
//   ALIGN_CHECK_EN defined:
//     - Addr[0]==1 on an IDLE request is rejected like Rd&Wr.
//     - err=1 for the cycle, no Stall, no array access.
//   ALIGN_CHECK_EN undefined:
//     - Addr[0] is ignored; odd addresses access word Addr[AW:1].
//     - err flags only Rd&Wr.
// TESTING
//   Wr=1, Addr=0x0010, DataIn=0xBEEF (1 cycle), then Rd=1, Addr=0x0010
//     -> Done at T+4, DataOut=0xBEEF; Stall high for exactly 4 cycles each access.
//   Rd held high through BUSY and DONE -> exactly one Done per access;
//     next acceptance no earlier than T+5.
//   Rd=1 and Wr=1 in IDLE -> err=1 for one cycle, Stall=0, Done never
//     pulses, array unchanged.
//   AW=9, Wr Addr=0x0402, DataIn=0x1234; then Rd Addr=0x0002
//     -> DataOut=0x1234 (alias/wrap).
//   Wr Addr=0x0020, DataIn=0xAAAA; assert rst at T+2
//     -> Stall/Done low immediately; a later Rd of 0x0020 returns the prior contents.
//   With ALIGN_CHECK_EN, Rd Addr=0x0011 -> err=1, no Stall.
//     Without it -> Done at T+4 with word 0x0010 data.
//   LATENCY=1 build -> Done in cycle T+1; Stall high only in cycle T.

Source files
------------

// File: rtl/data_mem_stall.sv
// data_mem_stall: multi-cycle data-memory responder that stalls the processor for LATENCY cycles per access.
// Optional ALIGN_CHECK_EN rejects odd byte addresses as illegal requests.
module data_mem_stall #(
   parameter int LATENCY = 4,
   parameter int AW = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_n;
   logic [3:0] cnt;
   logic op_wr;
   logic [AW-1:0] addr_q, wa;
   logic [15:0] data_q, wd;
   logic [15:0] mem [2**AW];
   logic req, bad, acc, fin, wr_op;
   logic unused_addr;
`ifdef ALIGN_CHECK_EN
   assign bad = Addr[0];
`else
   assign bad = 1'b0;
`endif
   assign unused_addr = ^{Addr[15:AW+1], Addr[0]};
   assign req = state == IDLE && (Rd ^ Wr);
   assign acc = req && !bad;
   assign err = state == IDLE && ((Rd && Wr) || (req && bad));
   assign Stall = acc || state == BUSY;
   assign Done = state == DONE;
   // With LATENCY==1 the access completes at the acceptance edge, so live inputs stand in for the latches
   assign fin = (state == BUSY && cnt == 4'd1) || (acc && LATENCY == 1);
   assign wa = state == IDLE ? Addr[AW:1] : addr_q;
   assign wd = state == IDLE ? DataIn : data_q;
   assign wr_op = state == IDLE ? Wr : op_wr;
   always_comb begin
      state_n = state;
      if (acc) state_n = LATENCY == 1 ? DONE : BUSY;
      else if (state == BUSY && cnt == 4'd1) state_n = DONE;
      else if (state == DONE) state_n = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         op_wr <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         DataOut <= '0;
      end else begin
         state <= state_n;
         if (acc) begin
            cnt <= 4'(LATENCY - 1);
            op_wr <= Wr;
            addr_q <= Addr[AW:1];
            data_q <= DataIn;
         end else if (state == BUSY) cnt <= cnt - 4'd1;
         if (fin && !wr_op) DataOut <= mem[wa];
      end
   end
   always_ff @(posedge clk) begin
      if (fin && wr_op && !rst) mem[wa] <= wd;
   end
endmodule

// File: tb/tb_data_mem_stall.sv
// tb_data_mem_stall: vector table plus scoreboard bench for data_mem_stall, with a LATENCY=1 side instance.
module tb_data_mem_stall;
   localparam int L = 4;
   localparam int AW = 9;
   logic clk = 1'b0, rst = 1'b1, Rd = 1'b0, Wr = 1'b0;
   logic [15:0] Addr = '0, DataIn = '0;
   logic [15:0] DataOut, DataOut1;
   logic Done, Stall, err, Done1, Stall1, err1;
   int errors = 0, checks = 0;
   logic [15:0] model [2**AW];
   logic [15:0] sb [$];
   typedef struct {logic rd; logic wr; logic [15:0] a; logic [15:0] d; logic e;} vec_t;
   vec_t tbl [12];
   logic align;

   data_mem_stall #(.LATENCY(L), .AW(AW)) dut (.clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn),
      .Rd(Rd), .Wr(Wr), .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err));
   data_mem_stall #(.LATENCY(1), .AW(AW)) u1 (.clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn),
      .Rd(Rd), .Wr(Wr), .DataOut(DataOut1), .Done(Done1), .Stall(Stall1), .err(err1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called and returns just after a rising edge
   task automatic run_access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                             input logic e);
      int lat, st;
      logic dn;
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      #1;
      if (e) begin
         chk("err_flag", err, 1);
         chk("err_stall", Stall, 0);
         @(posedge clk); #1;
         Rd = 0; Wr = 0; #1;
         chk("err_clear", err, 0);
         dn = 0;
         repeat (L + 2) begin @(posedge clk); #1; dn |= Done; end
         chk("err_nodone", dn, 0);
         return;
      end
      if (rd) sb.push_back(model[a[AW:1]]);
      else model[a[AW:1]] = d;
      lat = 0; st = 0;
      while (!Done && lat < 20) begin
         st += int'(Stall);
         @(posedge clk); #1;
         lat++;
         Rd = 0; Wr = 0; Addr = 16'($urandom); DataIn = 16'($urandom);
         #1;
      end
      chk("latency", lat, L);
      chk("stall_cycles", st, L);
      chk("done_stall", Stall, 0);
      if (rd && sb.size() > 0) chk("rdata", DataOut, sb.pop_front());
      @(posedge clk); #1;
      chk("done_pulse", Done, 0);
   endtask

   initial begin
      int lat, nd;
      logic dn;
`ifdef ALIGN_CHECK_EN
      align = 1;
`else
      align = 0;
`endif
      tbl[0]  = '{0, 1, 16'h0010, 16'hBEEF, 0};
      tbl[1]  = '{1, 0, 16'h0010, 16'h0000, 0};
      tbl[2]  = '{0, 1, 16'h0402, 16'h1234, 0};
      tbl[3]  = '{1, 0, 16'h0002, 16'h0000, 0};
      tbl[4]  = '{0, 1, 16'h03FE, 16'hC3C3, 0};
      tbl[5]  = '{1, 0, 16'h03FE, 16'h0000, 0};
      tbl[6]  = '{0, 1, 16'h0020, 16'h7777, 0};
      tbl[7]  = '{1, 1, 16'h0010, 16'h0000, 1};
      tbl[8]  = '{1, 0, 16'h0010, 16'h0000, 0};
      tbl[9]  = '{1, 0, 16'h0011, 16'h0000, align};
      tbl[10] = '{0, 1, 16'h0011, 16'h5555, align};
      tbl[11] = '{1, 0, 16'h0010, 16'h0000, 0};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", Done, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_err", err, 0);
      chk("rst_dout", DataOut, 0);
      rst = 0;
      @(posedge clk); #1;
      foreach (tbl[i]) run_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].e);
      // Rd held through the whole access: one Done, then a fresh acceptance right after it
      Rd = 1; Addr = 16'h0010; nd = 0;
      for (int c = 0; c <= L; c++) begin
         #1;
         nd += int'(Done);
         if (c == L) chk("held_done_at_TL", Done, 1);
         @(posedge clk); #1;
      end
      chk("held_one_done", nd, 1);
      #1;
      chk("reaccept_stall", Stall, 1);
      @(posedge clk); #1;
      Rd = 0; lat = 1;
      while (!Done && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("reaccept_lat", lat, L);
      chk("reaccept_data", DataOut, model[8'h08]);
      @(posedge clk); #1;
      chk("dout_held", DataOut, model[8'h08]);
      // Reset in the middle of a store discards it
      Wr = 1; Addr = 16'h0020; DataIn = 16'hAAAA;
      @(posedge clk); #1;
      Wr = 0;
      @(posedge clk); #1;
      chk("pre_rst_stall", Stall, 1);
      rst = 1; #1;
      chk("midrst_stall", Stall, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_dout", DataOut, 0);
      @(posedge clk); #1;
      rst = 0; dn = 0;
      repeat (L + 1) begin @(posedge clk); #1; dn |= Done; end
      chk("midrst_nodone", dn, 0);
      run_access(1, 0, 16'h0020, 16'h0000, 0);
      // LATENCY=1 instance
      Wr = 1; Addr = 16'h0040; DataIn = 16'h9999; #1;
      chk("l1_wr_stall", Stall1, 1);
      @(posedge clk); #1;
      Wr = 0; #1;
      chk("l1_wr_done", Done1, 1);
      chk("l1_wr_stall_done", Stall1, 0);
      @(posedge clk); #1;
      chk("l1_done_pulse", Done1, 0);
      Rd = 1; Addr = 16'h0040; #1;
      chk("l1_rd_stall", Stall1, 1);
      @(posedge clk); #1;
      Rd = 0; #1;
      chk("l1_rd_done", Done1, 1);
      chk("l1_rdata", DataOut1, 16'h9999);
      repeat (L + 2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
